nf_reg_file_mp: RTL
===================

Name: nf_reg_file_mp

Overview:
Parametrised multi-read-port integer register file with a self-clearing init sequencer and a pending-write scoreboard, for the pipelined nanoFOX core.
- Register 0 is hardwired to zero.
- Reads are combinational; the write port and scoreboard update on the clock edge.
- The scoreboard tracks registers with an issued but not yet written-back result, so decode can stall on RAW hazards.

Parameters:
XLEN, 32, data width of each register
DEPTH, 32, number of registers; power of two, at least 2
NUM_RD, 2, number of read ports; range 1..4
AW, $clog2(DEPTH), localparam, address width (not overridable)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
ra  input  NUM_RD*AW  read addresses; port i at [i*AW +: AW]
rd  output  NUM_RD*XLEN  read data; port i at [i*XLEN +: XLEN]
rd_busy  output  NUM_RD  port i: addressed register has a pending write
wa  input  AW  write address
wd  input  XLEN  write data
we  input  1  write enable
iss_v  input  1  issue valid: mark iss_a pending
iss_a  input  AW  destination register of the issued instruction
flush  input  1  clear all pending marks
init_done  output  1  high once clearing is complete

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- FSM states are INIT and RUN.
  - rst=1 forces INIT with clr_cnt=0 and all busy bits cleared, from any state, including mid-RUN.
- INIT:
  - Each cycle, writes 0 to mem[clr_cnt], then clr_cnt increments.
  - When clr_cnt==DEPTH-1 the FSM moves to RUN on the next edge.
  - Clearing takes exactly DEPTH cycles after rst deasserts.
  - init_done=0; rd=0 and rd_busy=0 on all ports; we, iss_v and flush are ignored.
- RUN:
  - init_done=1.
  - rd[i] = 0 if ra[i]==0, else mem[ra[i]].
  - Write: if we && wa!=0, mem[wa]<=wd at the edge; writes to 0 are dropped.
- Scoreboard: DEPTH-bit busy vector; busy[0] is always 0.
  - At each edge, clear bit wa if we, then set bit iss_a if iss_v && iss_a!=0.
  - If issue and write-back target the same address in the same cycle, set wins and the bit stays 1.
  - flush=1 clears every bit and overrides a same-cycle iss_v (the issue is squashed).
  - rd_busy[i] = busy[ra[i]], qualified as in Optional Feature.
- Reset values: init_done=0, rd=0, rd_busy=0, busy=0, FSM=INIT, clr_cnt=0.
- Memory contents are undefined until INIT finishes, and are never visible because rd is forced to 0.
- Read latency is 0 cycles (combinational from ra); write-to-read latency is 1 cycle, or 0 with the bypass.
- Out-of-range checks are unnecessary because DEPTH is a power of two.

Optional Feature:
Macro NF_REG_FILE_BYPASS_EN.
- Defined: in RUN, if we && wa!=0 && ra[i]==wa, then rd[i]=wd and rd_busy[i]=0 in the same cycle (write-through).
  - The bypass applies only when we is high.
- Undefined: no forwarding.
  - rd[i] shows the old contents until the next cycle.
  - rd_busy[i] reflects busy[ra[i]] unmodified (still 1 during the write-back cycle).

Decomposition:
- Package nf_reg_file_pkg holds:
  - enum rf_state_t {RF_INIT, RF_RUN};
  - default constants NF_RF_XLEN=32, NF_RF_DEPTH=32 and NF_RF_NUM_RD=2.
- Sub-module nf_rf_scoreboard: DEPTH-bit busy vector with set/clear/flush logic and NUM_RD lookup outputs.
- The storage array, init FSM and read muxes stay in nf_reg_file_mp.

Test Plan:
1. Init timing: rst=1 for 2 cycles, then deassert -> init_done=0 for exactly 32 cycles, then 1; reads of ra=5 and ra=31 return 0.
2. Write/read and x0: write wa=3, wd=0xDEADBEEF; write wa=0, wd=0x1234 -> next cycle rd(ra=3)=0xDEADBEEF and rd(ra=0)=0.
3. Bypass: same cycle we=1, wa=7, wd=0xA5A5A5A5, ra[1]=7 -> with macro, rd[1]=0xA5A5A5A5 that cycle; without macro, old value that cycle and the new value next cycle.
4. Scoreboard: iss_v with iss_a=9 -> rd_busy=1 for ra=9 until we with wa=9; same-cycle iss_a=9 and wa=9 -> busy stays 1.
5. Flush priority: busy set for regs 4 and 6; flush=1 with iss_v, iss_a=8 -> next cycle rd_busy=0 for ra=4, 6 and 8.
6. Reset mid-RUN: write reg 10 = 0x55; assert rst for 1 cycle -> init_done drops, 32 clearing cycles follow, then rd(ra=10)=0 and all busy bits are 0.

Source files
------------

// File: rtl/nf_reg_file_pkg.sv
// Shared types and default sizes for the nanoFOX multi-port register file.
// Build option NF_REG_FILE_BYPASS_EN (used in nf_reg_file_mp) enables write-through reads.
package nf_reg_file_pkg;

    localparam int unsigned NF_RF_XLEN   = 32;
    localparam int unsigned NF_RF_DEPTH  = 32;
    localparam int unsigned NF_RF_NUM_RD = 2;

    typedef enum logic {
        RF_INIT,
        RF_RUN
    } rf_state_t;

endpackage

// File: rtl/nf_rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on write-back,
// wiped by flush. Register 0 never reports busy.
module nf_rf_scoreboard
    import nf_reg_file_pkg::*;
#(
    parameter int unsigned  DEPTH  = NF_RF_DEPTH,
    parameter int unsigned  NUM_RD = NF_RF_NUM_RD,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_v,
    input  logic [AW-1:0]        clr_a,
    input  logic                 set_v,
    input  logic [AW-1:0]        set_a,
    input  logic                 flush,
    input  logic [NUM_RD*AW-1:0] ra,
    output logic [NUM_RD-1:0]    busy_rd
);

    logic [DEPTH-1:0] busy_q, busy_d;

    // Next busy vector: clear before set so a same-cycle issue to the written register wins.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (clr_v) begin
                busy_d[clr_a] = 1'b0;
            end
            if (set_v && (set_a != '0)) begin
                busy_d[set_a] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Per-port busy lookup.
    always_comb begin
        busy_rd = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            busy_rd[i] = busy_q[ra[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/nf_reg_file_mp.sv
// nanoFOX multi-read-port register file with self-clearing init sequencer and RAW scoreboard.
// Build option NF_REG_FILE_BYPASS_EN: forward same-cycle write data to matching read ports.
module nf_reg_file_mp
    import nf_reg_file_pkg::*;
#(
    parameter int unsigned  XLEN   = NF_RF_XLEN,
    parameter int unsigned  DEPTH  = NF_RF_DEPTH,
    parameter int unsigned  NUM_RD = NF_RF_NUM_RD,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   ra,
    output logic [NUM_RD*XLEN-1:0] rd,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [AW-1:0]          wa,
    input  logic [XLEN-1:0]        wd,
    input  logic                   we,
    input  logic                   iss_v,
    input  logic [AW-1:0]          iss_a,
    input  logic                   flush,
    output logic                   init_done
);

    logic [XLEN-1:0] mem [DEPTH];

    rf_state_t       state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            run;
    logic [NUM_RD-1:0] busy_rd;

    assign run       = (state_q == RF_RUN);
    assign init_done = run;

    // Init sequencer: walk every address once, then settle in RUN.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == RF_INIT) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == AW'(DEPTH - 1)) begin
                state_d = RF_RUN;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RF_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage: zero-fill during INIT, normal write port in RUN; no write while in reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                mem[clr_cnt_q] <= '0;
            end else if (we && (wa != '0)) begin
                mem[wa] <= wd;
            end
        end
    end

    // Scoreboard only sees traffic once the file is live.
    nf_rf_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .clr_v   (run & we),
        .clr_a   (wa),
        .set_v   (run & iss_v),
        .set_a   (iss_a),
        .flush   (run & flush),
        .ra      (ra),
        .busy_rd (busy_rd)
    );

    // Read ports: forced to zero outside RUN and for x0.
    always_comb begin
        rd      = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (run) begin
                if (ra[i*AW +: AW] != '0) begin
                    rd[i*XLEN +: XLEN] = mem[ra[i*AW +: AW]];
                end
                rd_busy[i] = busy_rd[i];
`ifdef NF_REG_FILE_BYPASS_EN
                if (we && (wa != '0) && (ra[i*AW +: AW] == wa)) begin
                    rd[i*XLEN +: XLEN] = wd;
                    rd_busy[i]         = 1'b0;
                end
`endif
            end
        end
    end

endmodule
